// File: rtl/chan_mux_sequencer.sv
// rtl/chan_mux_sequencer.sv - N:1 registered channel mux with static select and round-robin scan
// Optional feature macro: CHAN_MUX_SKIP_MASK_EN (adds ch_mask to skip channels while scanning).
module chan_mux_sequencer #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int DWELL = 3,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  din,
   input  logic [SELW-1:0] sel,
   input  logic            mode,
   input  logic            en,
`ifdef CHAN_MUX_SKIP_MASK_EN
   input  logic [N-1:0]    ch_mask,
`endif
   output logic [W-1:0]    dout,
   output logic            dout_valid,
   output logic [SELW-1:0] cur_ch,
   output logic            wrap,
   output logic            sel_err
);

   localparam logic [SELW:0]   N_VAL   = N[SELW:0];
   localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);
   localparam logic [7:0]      DW_LAST = 8'(DWELL - 1);

   logic [W-1:0]    ch_data [N];
   logic [7:0]      dwell_cnt, dwell_d;
   logic [SELW-1:0] ch_d, scan_next;
   logic            sel_ok, dwell_end, all_masked, load, wrap_d;

   for (genvar k = 0; k < N; k++) begin : g_split
      assign ch_data[k] = din[k*W +: W];
   end

   assign sel_ok    = ({1'b0, sel} < N_VAL);
   assign dwell_end = (dwell_cnt == DW_LAST);

`ifdef CHAN_MUX_SKIP_MASK_EN
   int unsigned     probe;
   logic            found;
   assign all_masked = &ch_mask;

   // Circular search for the first unmasked channel after cur_ch.
   always_comb begin
      scan_next = cur_ch;
      found     = 1'b0;
      probe     = 0;
      for (int i = 1; i <= N; i++) begin
         probe = (int'(cur_ch) + i) % N;
         if (!found && !ch_mask[SELW'(probe)]) begin
            found     = 1'b1;
            scan_next = SELW'(probe);
         end
      end
   end
`else
   assign all_masked = 1'b0;
   assign scan_next  = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
`endif

   always_comb begin
      ch_d    = cur_ch;
      dwell_d = dwell_cnt;
      wrap_d  = 1'b0;
      load    = 1'b0;
      if (!mode) begin
         dwell_d = '0;
         load    = 1'b1;
         if (sel_ok)
            ch_d = sel;
      end else if (all_masked) begin
         dwell_d = '0;
      end else begin
         load = 1'b1;
         if (dwell_end) begin
            dwell_d = '0;
            ch_d    = scan_next;
            // A non-increasing step means the scan went round the end.
            wrap_d  = (scan_next <= cur_ch);
         end else begin
            dwell_d = dwell_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         cur_ch     <= '0;
         wrap       <= 1'b0;
         sel_err    <= 1'b0;
         dwell_cnt  <= '0;
      end else if (en) begin
         cur_ch     <= ch_d;
         dwell_cnt  <= dwell_d;
         wrap       <= wrap_d;
         dout_valid <= load;
         if (load)
            dout <= ch_data[ch_d];
         if (!mode && !sel_ok)
            sel_err <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
         wrap       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chan_mux_sequencer.sv
// tb/tb_chan_mux_sequencer.sv - directed bench with behavioural model for chan_mux_sequencer
module tb_chan_mux_sequencer;
   localparam int N = 4, W = 8, DWELL = 3;

   logic           clk  = 1'b0;
   logic           rst  = 1'b1;
   logic [N*W-1:0] din  = 32'h4433_2211;
   logic [1:0]     sel  = 2'd1;
   logic           mode = 1'b0;
   logic           en   = 1'b1;
   logic [N-1:0]   ch_mask = '0;

   logic [W-1:0] dout, dout3;
   logic         dout_valid, dv3, wrap, wrap3, sel_err, se3;
   logic [1:0]   cur_ch, cur3;

   int n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   chan_mux_sequencer #(.N(N), .W(W), .DWELL(DWELL)) u_dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
`ifdef CHAN_MUX_SKIP_MASK_EN
      .ch_mask(ch_mask),
`endif
      .dout(dout), .dout_valid(dout_valid), .cur_ch(cur_ch), .wrap(wrap), .sel_err(sel_err)
   );

   chan_mux_sequencer #(.N(3), .W(W), .DWELL(DWELL)) u_dut3 (
      .clk(clk), .rst(rst), .din(din[3*W-1:0]), .sel(sel), .mode(mode), .en(en),
`ifdef CHAN_MUX_SKIP_MASK_EN
      .ch_mask(ch_mask[2:0]),
`endif
      .dout(dout3), .dout_valid(dv3), .cur_ch(cur3), .wrap(wrap3), .sel_err(se3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a channel is held for DWELL enabled scan edges, then the scan
   // moves to the next allowed channel; wrap means the index did not increase.
   logic       mask_all;
   logic [3:0] scan_mask;
`ifdef CHAN_MUX_SKIP_MASK_EN
   assign mask_all  = &ch_mask;
   assign scan_mask = ch_mask;
`else
   assign mask_all  = 1'b0;
   assign scan_mask = 4'b0000;
`endif

   function automatic int next_ch(input int c, input logic [3:0] msk);
      for (int i = 1; i <= N; i++)
         if (!msk[(c + i) % N]) return (c + i) % N;
      return c;
   endfunction

   int         m_ch = 0, m_age = 0;
   logic [7:0] m_dout = '0;
   bit         m_valid = 0, m_wrap = 0, m_err = 0;

   always @(posedge clk or posedge rst) begin : model
      int ch, age, nx;
      bit v, wr, er;
      if (rst) begin
         m_ch <= 0; m_age <= 0; m_dout <= '0; m_valid <= 0; m_wrap <= 0; m_err <= 0;
      end else if (!en) begin
         m_valid <= 0;
         m_wrap  <= 0;
      end else begin
         ch = m_ch; age = m_age; er = m_err; wr = 0; v = 1;
         if (!mode) begin
            age = 0;
            if (int'(sel) < N) ch = int'(sel);
            else er = 1;
         end else if (mask_all) begin
            age = 0;
            v   = 0;
         end else begin
            age = age + 1;
            if (age == DWELL) begin
               nx  = next_ch(ch, scan_mask);
               wr  = (nx <= ch);
               ch  = nx;
               age = 0;
            end
         end
         m_ch <= ch; m_age <= age; m_err <= er; m_wrap <= wr; m_valid <= v;
         if (v) m_dout <= din[ch*W +: W];
      end
   end

   always @(negedge clk) begin
      check("cmp_dout", 32'(dout), 32'(m_dout));
      check("cmp_valid", 32'(dout_valid), 32'(m_valid));
      check("cmp_cur_ch", 32'(cur_ch), 32'(m_ch));
      check("cmp_wrap", 32'(wrap), 32'(m_wrap));
      check("cmp_sel_err", 32'(sel_err), 32'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_ch [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

   initial begin
      #12 rst = 1'b0;
      tick();
      check("pre_rst_dout", 32'(dout), 32'h22);
      #2 rst = 1'b1;
      #1;
      check("async_rst_dout", 32'(dout), 32'h0);
      check("async_rst_valid", 32'(dout_valid), 32'h0);
      check("async_rst_cur_ch", 32'(cur_ch), 32'h0);
      check("async_rst_wrap", 32'(wrap), 32'h0);
      #4 rst = 1'b0;
      sel = 2'd2;
      tick();
      check("first_dout", 32'(dout), 32'h33);
      check("first_cur_ch", 32'(cur_ch), 32'd2);
      check("first_valid", 32'(dout_valid), 32'd1);

      sel = 2'd0;
      tick();
      check("static_dout", 32'(dout), 32'h11);
      check("static_cur_ch", 32'(cur_ch), 32'd0);
      check("static_wrap", 32'(wrap), 32'd0);

      mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("scan_cur_ch", 32'(cur_ch), 32'(exp_ch[i]));
         check("scan_dout", 32'(dout), 32'(8'h11 * (exp_ch[i] + 1)));
         check("scan_wrap", 32'(wrap), 32'(i == 11));
      end

      repeat (4) tick();
      check("mid_dwell_ch", 32'(cur_ch), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_dout", 32'(dout), 32'h22);
         check("hold_valid", 32'(dout_valid), 32'd0);
         check("hold_cur_ch", 32'(cur_ch), 32'd1);
      end
      en = 1'b1;
      tick();
      check("resume_ch", 32'(cur_ch), 32'd1);
      check("resume_valid", 32'(dout_valid), 32'd1);
      tick();
      check("advance_ch", 32'(cur_ch), 32'd2);
      check("advance_dout", 32'(dout), 32'h33);

      mode = 1'b0;
      sel  = 2'd1;
      tick();
      check("n3_cur_ch", 32'(cur3), 32'd1);
      check("n3_err_clear", 32'(se3), 32'd0);
      sel = 2'd3;
      tick();
      check("n3_bad_sel_ch", 32'(cur3), 32'd1);
      check("n3_bad_sel_dout", 32'(dout3), 32'h22);
      check("n3_sel_err", 32'(se3), 32'd1);
      check("n4_sel3_dout", 32'(dout), 32'h44);
      sel = 2'd1;
      tick();
      check("n3_err_sticky", 32'(se3), 32'd1);
      check("n3_back_ch", 32'(cur3), 32'd1);

`ifdef CHAN_MUX_SKIP_MASK_EN
      ch_mask = 4'b0101;
      mode    = 1'b1;
      for (int r = 0; r < 2; r++) begin
         repeat (3) tick();
         check("mask_to3", 32'(cur_ch), 32'd3);
         check("mask_to3_wrap", 32'(wrap), 32'd0);
         repeat (3) tick();
         check("mask_to1", 32'(cur_ch), 32'd1);
         check("mask_to1_wrap", 32'(wrap), 32'd1);
      end
      ch_mask = 4'b1111;
      repeat (2) begin
         tick();
         check("allmask_ch", 32'(cur_ch), 32'd1);
         check("allmask_dout", 32'(dout), 32'h22);
         check("allmask_valid", 32'(dout_valid), 32'd0);
      end
`endif

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/chan_mux_sequencer.md
Name: chan_mux_sequencer

Overview:
- Parametrised N:1 channel multiplexer with a registered output; successor to the single-bit 2:1 select mux.
- Two modes: static (channel chosen by `sel`) and auto-scan (channel advances round-robin after a programmable dwell).
- Sits between the `ui_in` / `uio_in` pin banks and `uo_out` inside the top-level wrapper.
- Exports the current channel index and a wrap strobe so a downstream sampler can tag data.

Parameters:
- N, 4, number of input channels (2..16)
- W, 8, data width per channel
- DWELL, 3, cycles spent on each channel in scan mode (1..255)
- SELW, $clog2(N), width of channel index (derived, not overridable)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- din  input  N*W  packed channels; channel k = din[k*W +: W]
- sel  input  SELW  static-mode channel select
- mode  input  1  0 = static, 1 = auto-scan
- en  input  1  global enable; 0 freezes all state
- dout  output  W  registered selected data
- dout_valid  output  1  dout updated this cycle
- cur_ch  output  SELW  channel index that dout belongs to
- wrap  output  1  one-cycle pulse when the scan wraps from N-1 to 0
- sel_err  output  1  sticky: sel >= N was seen in static mode

Behaviour:
- Reset (asynchronous, active-high) forces: dout=0, dout_valid=0, cur_ch=0, wrap=0, sel_err=0, internal dwell_cnt=0.
- Next channel ch_d:
  - en=0: ch_d = cur_ch.
  - Static mode: ch_d = sel.
  - Scan mode: ch_d = (cur_ch+1) mod N if dwell_cnt == DWELL-1, else cur_ch.
- Each clock edge with en=1:
  - cur_ch <= ch_d
  - dout <= din[ch_d]
  - dout_valid <= 1
- Latency: one cycle from sel/din to dout. dout and cur_ch always update together and correspond to each other.
- en=0: dout, cur_ch, dwell_cnt and sel_err hold; dout_valid <= 0; wrap <= 0.
- Static mode, sel >= N (N not a power of 2):
  - ch_d = cur_ch (hold the previous channel).
  - dout still reloads from that channel.
  - sel_err <= 1, sticky until reset.
- Static mode: dwell_cnt <= 0 every enabled cycle.
- Scan mode: dwell_cnt increments each enabled cycle and clears to 0 when it reaches DWELL-1. With DWELL=1 the channel advances every cycle.
- wrap <= 1 for exactly one cycle, on the edge where cur_ch goes N-1 -> 0 in scan mode; 0 otherwise. Static-mode select changes never assert wrap.
- Mode change static -> scan: scanning starts from the current cur_ch; dwell_cnt is already 0, so the first advance comes DWELL cycles later.
- Mode change scan -> static: the very next edge loads sel; dwell_cnt clears.
- Reset mid-scan: immediate return to channel 0 with all outputs at their reset values. The first enabled edge after reset release loads channel 0 (scan) or sel (static).
- din is sampled only at clock edges; no combinational path from any input to any output.

Optional Feature:
- Macro: CHAN_MUX_SKIP_MASK_EN
- With the macro defined:
  - Adds input `ch_mask` [N-1:0]; bit k=1 excludes channel k from scanning.
  - Scan advance picks the next unmasked channel after cur_ch, searching circularly.
  - wrap pulses when the selected index is numerically <= the previous index.
  - If all channels are masked: cur_ch and dout hold, and dout_valid <= 0 while all-masked persists.
  - Static mode ignores ch_mask.
- Without the macro: no ch_mask port; scan visits every channel 0..N-1.

Test Plan (N=4, W=8, DWELL=3, din = {8'h44, 8'h33, 8'h22, 8'h11}):
- Reset: assert rst mid-cycle -> outputs go to 0 immediately without waiting for a clock edge; after release, mode=0, sel=2, en=1 -> next edge gives dout=0x33, cur_ch=2, dout_valid=1.
- Static select change: sel 2 -> 0 -> next edge dout=0x11, cur_ch=0, wrap stays 0.
- Scan mode from ch 0 -> cur_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 on successive edges; dout tracks 0x11..0x44; wrap=1 only on the 3 -> 0 edge.
- en=0 for 5 cycles mid-dwell on ch 1 -> dout=0x22 held, dout_valid=0; after en=1, ch 1 finishes its remaining dwell, then advances to 2.
- N=3 build, static sel=3 -> cur_ch holds previous value, sel_err=1 and remains 1 after sel returns to 1.
- CHAN_MUX_SKIP_MASK_EN, ch_mask=4'b0101, scan -> cur_ch sequence 1,3,1,3 (each held 3 cycles), wrap on each 3 -> 1 edge; ch_mask=4'b1111 -> cur_ch and dout hold, dout_valid=0.
